// File: rtl/npu_conv_window_reader.sv
// npu_conv_window_reader
// Loads a K x K weight set from the conv parameter RAM, then walks every
// K x K window of the image (with configurable stride). For each window it
// gathers all NUM_BANKS channels through one shared image RAM address.
// Each window is presented to the MAC array over valid/ready, together with
// its linear output index and first/last markers.
module npu_conv_window_reader #(
    parameter int DATA_W     = 8,
    parameter int NUM_BANKS  = 4,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int K          = 3,
    parameter int STRIDE     = 1,
    parameter int IMG_ADDR_W = 10,
    parameter int PAR_ADDR_W = 15,
    parameter int OUT_ADDR_W = 14
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PAR_ADDR_W-1:0]             param_base,
    output logic                              busy,
    output logic                              done,
    output logic [IMG_ADDR_W-1:0]             img_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]       img_rdata,
    output logic [PAR_ADDR_W-1:0]             par_addr,
    input  logic [DATA_W-1:0]                 par_rdata,
    output logic [K*K*DATA_W-1:0]             weights,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic [NUM_BANKS*K*K*DATA_W-1:0]   win_data,
    output logic [OUT_ADDR_W-1:0]             win_out_addr,
    output logic                              win_first,
    output logic                              win_last
);

    localparam int KK     = K * K;
    localparam int OUT_W  = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H  = (IMG_H - K) / STRIDE + 1;
    localparam int N_WIN  = OUT_W * OUT_H;
    localparam int CNT_W  = $clog2(KK + 1) + 1;
    localparam int RC_MAX = (OUT_W > OUT_H) ? OUT_W : OUT_H;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD_PARAM = 3'd1;
    localparam logic [2:0] S_FETCH      = 3'd2;
    localparam logic [2:0] S_EMIT       = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]            state;
    // Cycle index inside LOAD_PARAM / FETCH: issue slot cnt, capture slot cnt-1.
    logic [CNT_W-1:0]      cnt;
    // Output-grid position of the window being fetched/presented.
    logic [RC_W-1:0]       row_q;
    logic [RC_W-1:0]       col_q;
    // Image address of element (0,0) of the current window and of its grid row.
    logic [IMG_ADDR_W-1:0] win_base_q;
    logic [IMG_ADDR_W-1:0] row_base_q;
    // Address of element (i,0) for the window row currently being issued.
    logic [IMG_ADDR_W-1:0] line_addr_q;
    // Column j of the element currently being issued.
    logic [CNT_W-1:0]      j_q;

    logic                  col_wrap;
    logic                  last_win;
    logic [IMG_ADDR_W-1:0] next_base;

    // Next window origin: step right by STRIDE, or drop STRIDE rows at the row end.
    always_comb begin
        col_wrap  = (col_q == RC_W'(OUT_W - 1));
        last_win  = col_wrap && (row_q == RC_W'(OUT_H - 1));
        next_base = win_base_q + IMG_ADDR_W'(STRIDE);
        if (col_wrap) begin
            next_base = row_base_q + IMG_ADDR_W'(STRIDE * IMG_W);
        end
    end

    assign busy      = (state == S_LOAD_PARAM) || (state == S_FETCH) || (state == S_EMIT);
    assign done      = (state == S_DONE);
    assign win_valid = (state == S_EMIT);
    // Markers are qualified by valid so that they read 0 while nothing is presented.
    assign win_first = win_valid && (win_out_addr == '0);
    assign win_last  = win_valid && (win_out_addr == OUT_ADDR_W'(N_WIN - 1));

    // Controller, address generation and capture of weights / window pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            win_base_q   <= '0;
            row_base_q   <= '0;
            line_addr_q  <= '0;
            j_q          <= '0;
            img_addr     <= '0;
            par_addr     <= '0;
            weights      <= '0;
            win_data     <= '0;
            win_out_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD_PARAM;
                        par_addr     <= param_base;
                        cnt          <= '0;
                        row_q        <= '0;
                        col_q        <= '0;
                        win_base_q   <= '0;
                        row_base_q   <= '0;
                        win_out_addr <= '0;
                    end
                end

                S_LOAD_PARAM: begin
                    for (int e = 0; e < KK; e++) begin
                        if (cnt == CNT_W'(e + 1)) begin
                            weights[e*DATA_W +: DATA_W] <= par_rdata;
                        end
                    end
                    if (cnt < CNT_W'(KK - 1)) begin
                        par_addr <= par_addr + PAR_ADDR_W'(1);
                    end
                    if (cnt == CNT_W'(KK)) begin
                        state       <= S_FETCH;
                        cnt         <= '0;
                        img_addr    <= win_base_q;
                        line_addr_q <= win_base_q;
                        j_q         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_FETCH: begin
                    for (int e = 0; e < KK; e++) begin
                        if (cnt == CNT_W'(e + 1)) begin
                            for (int b = 0; b < NUM_BANKS; b++) begin
                                win_data[(b*KK + e)*DATA_W +: DATA_W] <= img_rdata[b*DATA_W +: DATA_W];
                            end
                        end
                    end
                    if (cnt < CNT_W'(KK - 1)) begin
                        if (j_q == CNT_W'(K - 1)) begin
                            line_addr_q <= line_addr_q + IMG_ADDR_W'(IMG_W);
                            img_addr    <= line_addr_q + IMG_ADDR_W'(IMG_W);
                            j_q         <= '0;
                        end else begin
                            img_addr <= img_addr + IMG_ADDR_W'(1);
                            j_q      <= j_q + CNT_W'(1);
                        end
                    end
                    if (cnt == CNT_W'(KK)) begin
                        state <= S_EMIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_EMIT: begin
                    if (win_ready) begin
                        if (last_win) begin
                            state <= S_DONE;
                        end else begin
                            state        <= S_FETCH;
                            cnt          <= '0;
                            win_out_addr <= win_out_addr + OUT_ADDR_W'(1);
                            win_base_q   <= next_base;
                            img_addr     <= next_base;
                            line_addr_q  <= next_base;
                            j_q          <= '0;
                            if (col_wrap) begin
                                col_q      <= '0;
                                row_q      <= row_q + RC_W'(1);
                                row_base_q <= next_base;
                            end else begin
                                col_q <= col_q + RC_W'(1);
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_conv_window_reader.sv
// Bench for npu_conv_window_reader: one stride-1 instance and one stride-2
// instance on a shared clock, fed by synchronous RAM models with 1-cycle latency.
module tb_npu_conv_window_reader;

    localparam int DW  = 8;
    localparam int NB  = 4;
    localparam int KS  = 3;
    localparam int KK  = 9;
    localparam int IW  = 16;
    localparam int WDW = NB * KK * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic              a_start, a_busy, a_done, a_win_valid, a_win_ready, a_win_first, a_win_last;
    logic [14:0]       a_param_base, a_par_addr;
    logic [9:0]        a_img_addr;
    logic [NB*DW-1:0]  a_img_rdata;
    logic [DW-1:0]     a_par_rdata;
    logic [KK*DW-1:0]  a_weights;
    logic [WDW-1:0]    a_win_data;
    logic [13:0]       a_win_out_addr;

    logic              b_start, b_busy, b_done, b_win_valid, b_win_ready, b_win_first, b_win_last;
    logic [14:0]       b_param_base, b_par_addr;
    logic [9:0]        b_img_addr;
    logic [NB*DW-1:0]  b_img_rdata;
    logic [DW-1:0]     b_par_rdata;
    logic [KK*DW-1:0]  b_weights;
    logic [WDW-1:0]    b_win_data;
    logic [13:0]       b_win_out_addr;

    npu_conv_window_reader u_a (
        .clk(clk), .reset(reset), .start(a_start), .param_base(a_param_base),
        .busy(a_busy), .done(a_done), .img_addr(a_img_addr), .img_rdata(a_img_rdata),
        .par_addr(a_par_addr), .par_rdata(a_par_rdata), .weights(a_weights),
        .win_valid(a_win_valid), .win_ready(a_win_ready), .win_data(a_win_data),
        .win_out_addr(a_win_out_addr), .win_first(a_win_first), .win_last(a_win_last)
    );

    npu_conv_window_reader #(.STRIDE(2)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .param_base(b_param_base),
        .busy(b_busy), .done(b_done), .img_addr(b_img_addr), .img_rdata(b_img_rdata),
        .par_addr(b_par_addr), .par_rdata(b_par_rdata), .weights(b_weights),
        .win_valid(b_win_valid), .win_ready(b_win_ready), .win_data(b_win_data),
        .win_out_addr(b_win_out_addr), .win_first(b_win_first), .win_last(b_win_last)
    );

    logic [7:0] img_mem [NB][1024];
    logic [7:0] par_mem [32768];

    int evals = 0;
    int fails = 0;
    int cyc = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;

    // RAM models and event counters
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            a_img_rdata[b*DW +: DW] <= img_mem[b][a_img_addr];
            b_img_rdata[b*DW +: DW] <= img_mem[b][b_img_addr];
        end
        a_par_rdata <= par_mem[a_par_addr];
        b_par_rdata <= par_mem[b_par_addr];
        cyc <= cyc + 1;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 1024; a++) img_mem[b][a] = 8'((a + b) & 255);
        for (int a = 0; a < 32768; a++) par_mem[a] = 8'((a * 2) & 255);
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 1024; a++) img_mem[b][a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 32768; a++) par_mem[a] = 8'($urandom_range(0, 255));
    endtask

    // Window idx of the output grid: element (i,j) of bank b comes from
    // image pixel (r*stride+i, c*stride+j).
    function automatic logic [WDW-1:0] exp_win(input int stride, input int idx);
        int ow, r, c;
        logic [WDW-1:0] v;
        ow = (IW - KS) / stride + 1;
        r  = idx / ow;
        c  = idx % ow;
        v  = '0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < KS; i++)
                for (int j = 0; j < KS; j++)
                    v[(b*KK + i*KS + j)*DW +: DW] = img_mem[b][(r*stride + i)*IW + c*stride + j];
        return v;
    endfunction

    function automatic logic [KK*DW-1:0] exp_wts(input int base);
        logic [KK*DW-1:0] v;
        for (int e = 0; e < KK; e++) v[e*DW +: DW] = par_mem[(base + e) % 32768];
        return v;
    endfunction

    int widx, guard, n, c0, last_cyc, pb;
    int exp_addr [9];
    logic [WDW-1:0] hold_data;
    logic [9:0]     hold_addr;

    initial begin
        exp_addr = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        reset = 1'b1;
        a_start = 1'b0; a_param_base = '0; a_win_ready = 1'b0;
        b_start = 1'b0; b_param_base = '0; b_win_ready = 1'b0;
        fill_pattern();
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_valid", a_win_valid, 1'b0);
        chk("rst_img_addr", a_img_addr, 10'd0);
        chk("rst_par_addr", a_par_addr, 15'd0);
        chk("rst_weights", a_weights, '0);
        chk("rst_win_data", a_win_data, '0);
        chk("rst_out_addr", a_win_out_addr, 14'd0);
        chk("rst_first", a_win_first, 1'b0);
        chk("rst_last", a_win_last, 1'b0);
        chk("rst_b_busy", b_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Pass 1: deterministic pattern, stride 1, backpressure on window 7
        a_win_ready  = 1'b1;
        a_param_base = 15'd100;
        a_start      = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        c0 = cyc;
        chk("a_busy_rise", a_busy, 1'b1);
        chk("a_par_addr_0", a_par_addr, 15'd100);
        for (int e = 1; e < KK; e++) begin
            @(negedge clk);
            chk("a_par_addr_seq", a_par_addr, 15'(100 + e));
        end
        @(negedge clk);
        chk("a_par_addr_hold", a_par_addr, 15'd108);
        @(negedge clk);
        chk("a_fetch_addr_0", a_img_addr, 10'(exp_addr[0]));
        chk("a_fetch_no_valid", a_win_valid, 1'b0);
        for (int t = 1; t < KK; t++) begin
            @(negedge clk);
            chk("a_fetch_addr_seq", a_img_addr, 10'(exp_addr[t]));
        end

        last_cyc = 0;
        for (int idx = 0; idx < 196; idx++) begin
            n = 0;
            while (!a_win_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("a_wait_valid", a_win_valid, 1'b1);
            if (!a_win_valid) break;
            if (idx == 0) begin
                chk("a_first_latency", cyc - c0, 20);
                chk("a_weights", a_weights, 72'(exp_wts(100)));
                chk("a_w0", a_weights[7:0], 8'd200);
                chk("a_w8", a_weights[71:64], 8'd216);
                chk("a_b3_e0", a_win_data[(3*KK)*DW +: DW], 8'd3);
                chk("a_b3_e8", a_win_data[(3*KK+8)*DW +: DW], 8'd37);
                chk("a_b0_e5", a_win_data[5*DW +: DW], 8'd18);
            end else begin
                chk("a_spacing", cyc - last_cyc, (idx == 8) ? 16 : 11);
            end
            if (idx == 14) chk("a_idx14_base", a_win_data[7:0], 8'd16);
            last_cyc = cyc;
            chk("a_data", a_win_data, exp_win(1, idx));
            chk("a_out_addr", a_win_out_addr, 14'(idx));
            chk("a_first", a_win_first, idx == 0);
            chk("a_last", a_win_last, idx == 195);
            chk("a_no_done", a_done, 1'b0);
            if (idx == 7) begin
                a_win_ready = 1'b0;
                hold_data   = a_win_data;
                hold_addr   = a_img_addr;
                repeat (5) begin
                    @(negedge clk);
                    chk("a_bp_valid", a_win_valid, 1'b1);
                    chk("a_bp_data", a_win_data, hold_data);
                    chk("a_bp_img_addr", a_img_addr, hold_addr);
                    chk("a_bp_out_addr", a_win_out_addr, 14'd7);
                end
                a_win_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("a_done_pulse", a_done, 1'b1);
        chk("a_done_busy", a_busy, 1'b0);
        @(negedge clk);
        chk("a_done_single", a_done, 1'b0);
        chk("a_done_cnt1", a_done_cnt, 1);

        // Pass 2: stride 2 instance, random data and random backpressure
        fill_random();
        pb = $urandom_range(0, 32767);
        b_param_base = 15'(pb);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        widx = 0; guard = 0;
        b_win_ready = 1'($urandom_range(0, 1));
        while (widx < 49 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (b_win_valid) begin
                chk("b_data", b_win_data, exp_win(2, widx));
                chk("b_out_addr", b_win_out_addr, 14'(widx));
                chk("b_first", b_win_first, widx == 0);
                chk("b_last", b_win_last, widx == 48);
                if (widx == 0) chk("b_weights", b_weights, 72'(exp_wts(pb)));
                if (widx == 1) chk("b_idx1_base", b_win_data[7:0], img_mem[0][2]);
                if (widx == 7) chk("b_idx7_base", b_win_data[7:0], img_mem[0][32]);
            end
            b_win_ready = 1'($urandom_range(0, 1));
            if (b_win_valid && b_win_ready) widx++;
        end
        chk("b_window_count", widx, 49);
        @(negedge clk);
        chk("b_done_pulse", b_done, 1'b1);
        @(negedge clk);
        chk("b_done_cnt", b_done_cnt, 1);
        chk("b_idle", b_busy, 1'b0);

        // Pass 3: start ignored mid-pass, then reset during window 3 fetch
        pb = $urandom_range(0, 32767);
        a_param_base = 15'(pb);
        a_win_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (12) @(negedge clk);
        a_param_base = 15'(pb ^ 32'h1234);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("c_start_ignored_busy", a_busy, 1'b1);
        for (int idx = 0; idx < 3; idx++) begin
            n = 0;
            while (!a_win_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("c_wait_valid", a_win_valid, 1'b1);
            chk("c_data", a_win_data, exp_win(1, idx));
            chk("c_out_addr", a_win_out_addr, 14'(idx));
            chk("c_weights", a_weights, 72'(exp_wts(pb)));
            @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("c_rst_busy", a_busy, 1'b0);
        chk("c_rst_valid", a_win_valid, 1'b0);
        chk("c_rst_done", a_done, 1'b0);
        chk("c_rst_img_addr", a_img_addr, 10'd0);
        chk("c_rst_par_addr", a_par_addr, 15'd0);
        chk("c_rst_data", a_win_data, '0);
        chk("c_rst_weights", a_weights, '0);
        chk("c_rst_out_addr", a_win_out_addr, 14'd0);
        @(negedge clk);
        chk("c_no_done_pulse", a_done_cnt, 1);
        chk("c_still_idle", a_busy, 1'b0);

        // Fresh full pass after the abort, random backpressure
        pb = $urandom_range(0, 32767);
        a_param_base = 15'(pb);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        widx = 0; guard = 0;
        a_win_ready = 1'($urandom_range(0, 1));
        while (widx < 196 && guard < 8000) begin
            @(negedge clk);
            guard++;
            if (a_win_valid) begin
                chk("d_data", a_win_data, exp_win(1, widx));
                chk("d_out_addr", a_win_out_addr, 14'(widx));
                chk("d_first", a_win_first, widx == 0);
                chk("d_last", a_win_last, widx == 195);
                if (widx == 0) chk("d_weights", a_weights, 72'(exp_wts(pb)));
            end
            a_win_ready = 1'($urandom_range(0, 1));
            if (a_win_valid && a_win_ready) widx++;
        end
        chk("d_window_count", widx, 196);
        @(negedge clk);
        chk("d_done_pulse", a_done, 1'b1);
        @(negedge clk);
        chk("d_done_cnt", a_done_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
